mem_port_arbiter: RTL

Shares one single-port unified instruction/data memory between the fetch stage (read-only) and the memory stage (read/write) of the 5-stage MIPS pipeline. It arbitrates, sequences each access through a fixed-latency memory, and returns read data with a one-cycle valid pulse. It drives stall_if and stall_m into the hazard/stall network so the pipeline holds while an access is pending. Data accesses have priority, and a streak limit bounds how long fetch can be starved.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_IF   = 2'd1,
    GRANT_M    = 2'd2
  } grant_t;

  // Payload latched at grant time; the requester may change its own copy afterwards.
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // Bits needed to hold a streak count in 0..max.
  function automatic int unsigned streak_w(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports, stall outputs and the memory-side bus of the arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_valid;
  logic              stall_if;
  logic              stall_m;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, m_req, m_we, m_addr, m_wdata, mem_rdata,
    output if_rdata, if_valid, m_rdata, m_valid, stall_if, stall_m,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Pipeline / memory side.
  modport master (
    output if_req, if_addr, m_req, m_we, m_addr, m_wdata, mem_rdata,
    input  if_rdata, if_valid, m_rdata, m_valid, stall_if, stall_m,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection and next-streak computation; data wins unless fetch has starved long enough.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned SW         = streak_w(MAX_STREAK)
) (
  input  logic          if_req,
  input  logic          m_req,
  input  logic [SW-1:0] streak,
  output grant_t        grant,
  output logic [SW-1:0] streak_next
);

  localparam logic [SW-1:0] StreakMax = SW'(MAX_STREAK);

  // Pick the winner and the streak value to commit if the grant is taken.
  always_comb begin
    grant       = GRANT_NONE;
    streak_next = streak;
    if (m_req && !(if_req && (streak == StreakMax))) begin
      grant = GRANT_M;
      if (!if_req) begin
        streak_next = '0;
      end else if (streak != StreakMax) begin
        streak_next = streak + SW'(1);
      end
    end else if (if_req) begin
      grant       = GRANT_IF;
      streak_next = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and data accesses onto one fixed-latency single-port memory.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_port_arbiter_if.slave       bus
);

  localparam int unsigned SW = streak_w(MAX_STREAK);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  arb_state_t        state_q, state_d;
  grant_t            grant_q, grant_d;
  mem_req_t          req_q, req_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_en_q, mem_en_d;
  logic              if_valid_q, if_valid_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;

  grant_t            pick_grant;
  logic [SW-1:0]     pick_streak;
  logic [ADDR_W-1:0] sel_addr;

  mem_arb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_pick (
    .if_req      (bus.if_req),
    .m_req       (bus.m_req),
    .streak      (streak_q),
    .grant       (pick_grant),
    .streak_next (pick_streak)
  );

  // State and response registers; reset abandons any in-flight access silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= GRANT_NONE;
      req_q      <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      mem_en_q   <= 1'b0;
      if_valid_q <= 1'b0;
      m_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      m_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      mem_en_q   <= mem_en_d;
      if_valid_q <= if_valid_d;
      m_valid_q  <= m_valid_d;
      if_rdata_q <= if_rdata_d;
      m_rdata_q  <= m_rdata_d;
    end
  end

  // Next-state: grant in IDLE, strobe in ISSUE, count out latency in WAIT, pulse valid in RESP.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    mem_en_d   = 1'b0;
    if_valid_d = 1'b0;
    m_valid_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    m_rdata_d  = m_rdata_q;
    sel_addr   = bus.if_addr;
    unique case (state_q)
      IDLE: begin
        if (pick_grant != GRANT_NONE) begin
          grant_d  = pick_grant;
          streak_d = pick_streak;
          if (pick_grant == GRANT_M) begin
            sel_addr    = bus.m_addr;
            req_d.we    = bus.m_we;
            req_d.wdata = bus.m_wdata;
          end else begin
            req_d.we    = 1'b0;
            req_d.wdata = '0;
          end
          req_d.addr = sel_addr;
          mem_en_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (grant_q == GRANT_IF) begin
            if_rdata_d = bus.mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!req_q.we) begin
              m_rdata_d = bus.mem_rdata;
            end
            m_valid_d = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        grant_d = GRANT_NONE;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.m_rdata   = m_rdata_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_en_q & req_q.we;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.busy      = (state_q != IDLE);
  // Stall drops in the valid cycle so the requesting stage advances.
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_m   = bus.m_req & ~m_valid_q;

endmodule
